// File: rtl/ibex_instr_mem_pkg.sv
// Shared types and helpers for the instruction SRAM adapter and its response pipe.
// Holds the response tag carried alongside each granted fetch and the window check.
package ibex_instr_mem_pkg;

   localparam int unsigned MaxReadLatency      = 4;
   localparam int unsigned MaxOutstandingLimit = 4;

   typedef struct packed {
      logic valid;
      logic err;
   } rsp_tag_t;

   // Evaluated in 33 bits so a window ending at 2^32 does not wrap to zero.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [30:0] size_words);
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + {size_words, 2'b00};
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/ibex_instr_rsp_pipe.sv
// Fixed-depth delay line for response tags, with SRAM data joining at stage 1.
// Latency Depth cycles from tag_i to tag_o; no backpressure, clr_i empties it synchronously.
module ibex_instr_rsp_pipe
   import ibex_instr_mem_pkg::*;
#(
   parameter int unsigned Depth = 1
) (
   input  logic        clk_i,
   input  logic        clr_i,
   input  rsp_tag_t    tag_i,
   input  logic [31:0] sram_rdata_i,
   output rsp_tag_t    tag_o,
   output logic [31:0] rdata_o
);

   rsp_tag_t tag_q [Depth];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int i = 0; i < Depth; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= tag_i;
         for (int i = 1; i < Depth; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign tag_o = tag_q[Depth-1];

   if (Depth == 1) begin : gen_direct
      // SRAM data is valid exactly when the tag leaves the single stage.
      assign rdata_o = sram_rdata_i;
   end else begin : gen_staged
      logic [31:0] data_q [1:Depth-1];

      always_ff @(posedge clk_i) begin
         if (clr_i) begin
            for (int i = 1; i < Depth; i++) begin
               data_q[i] <= '0;
            end
         end else begin
            data_q[1] <= sram_rdata_i;
            for (int i = 2; i < Depth; i++) begin
               data_q[i] <= data_q[i-1];
            end
         end
      end

      assign rdata_o = data_q[Depth-1];
   end

endmodule

// File: rtl/ibex_instr_sram_adapter.sv
// Prefetch-buffer instruction bus responder in front of a 1-cycle-latency SRAM.
// rvalid ReadLatency cycles after gnt; gnt throttled by MaxOutstanding, rvalid never stalls.
module ibex_instr_sram_adapter
   import ibex_instr_mem_pkg::*;
#(
   parameter logic [31:0] MemBase        = 32'h0000_0000,
   parameter int unsigned MemSizeWords   = 4096,
   parameter int unsigned ReadLatency    = 1,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            instr_req_i,
   input  logic [31:0]                     instr_addr_i,
   output logic                            instr_gnt_o,
   output logic                            instr_rvalid_o,
   output logic [31:0]                     instr_rdata_o,
   output logic                            instr_err_o,
   output logic                            sram_req_o,
   output logic [$clog2(MemSizeWords)-1:0] sram_addr_o,
   input  logic [31:0]                     sram_rdata_i,
   output logic                            busy_o
);

   localparam int unsigned AW = $clog2(MemSizeWords);
   localparam int unsigned CW = $clog2(MaxOutstanding + 1);

   if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : gen_bad_latency
      $error("ibex_instr_sram_adapter: ReadLatency must be 1..4");
   end
   if (MaxOutstanding < 1 || MaxOutstanding > MaxOutstandingLimit) begin : gen_bad_outstanding
      $error("ibex_instr_sram_adapter: MaxOutstanding must be 1..4");
   end
   if (MemSizeWords < 2 || (MemSizeWords & (MemSizeWords - 1)) != 0) begin : gen_bad_size
      $error("ibex_instr_sram_adapter: MemSizeWords must be a power of two >= 2");
   end
   if (MemBase[1:0] != 2'b00) begin : gen_bad_base
      $error("ibex_instr_sram_adapter: MemBase must be word aligned");
   end

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          retire;
   logic          gnt;
   logic          in_range;
   logic [31:0]   offset;
   logic          unused_offset;
   logic [31:0]   pipe_rdata;
   rsp_tag_t      push_tag;
   rsp_tag_t      rsp_tag;

   // Outputs are masked while reset is held so nothing granted earlier can be returned,
   // and no new request is accepted into a pipe that is being cleared.
   assign retire   = rsp_tag.valid & ~rst_i;
   assign gnt      = ~rst_i & instr_req_i & ((cnt_q < CW'(MaxOutstanding)) | retire);
   assign in_range = addr_in_range(instr_addr_i, MemBase, 31'(MemSizeWords));

   assign offset        = instr_addr_i - MemBase;
   assign unused_offset = ^offset;

   assign push_tag.valid = gnt;
   assign push_tag.err   = gnt & ~in_range;

   ibex_instr_rsp_pipe #(
      .Depth (ReadLatency)
   ) u_rsp_pipe (
      .clk_i        (clk_i),
      .clr_i        (rst_i),
      .tag_i        (push_tag),
      .sram_rdata_i (sram_rdata_i),
      .tag_o        (rsp_tag),
      .rdata_o      (pipe_rdata)
   );

   assign cnt_d = cnt_q + CW'(gnt) - CW'(retire);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign instr_gnt_o    = gnt;
   assign instr_rvalid_o = retire;
   assign instr_err_o    = retire & rsp_tag.err;
   assign instr_rdata_o  = (retire & ~rsp_tag.err) ? pipe_rdata : 32'h0;
   assign sram_req_o     = gnt & in_range;
   assign sram_addr_o    = sram_req_o ? offset[2 +: AW] : '0;
   assign busy_o         = ~rst_i & ((cnt_q != '0) | instr_req_i);

`ifndef SYNTHESIS
   logic [ReadLatency-1:0] gnt_hist_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gnt_hist_q <= '0;
      end else begin
         gnt_hist_q <= (gnt_hist_q << 1) | ReadLatency'(instr_gnt_o);
      end
   end

   a_gnt_needs_req : assert property (@(posedge clk_i) instr_gnt_o |-> instr_req_i);
   a_no_underflow  : assert property (@(posedge clk_i) disable iff (rst_i)
                                      retire |-> (cnt_q != '0));
   a_cnt_bounded   : assert property (@(posedge clk_i) disable iff (rst_i)
                                      cnt_q <= CW'(MaxOutstanding));
   a_rsp_timing    : assert property (@(posedge clk_i) disable iff (rst_i)
                                      instr_rvalid_o == gnt_hist_q[ReadLatency-1]);
`endif

endmodule

// File: doc/ibex_instr_sram_adapter.md
Name: ibex_instr_sram_adapter

Overview:
Upstream responder for the prefetch buffer's instruction bus. Terminates the core-side req/gnt/rvalid protocol and drives a single-port instruction SRAM with a fixed 1-cycle read latency. Supports a configurable response latency and bounded outstanding requests. Returns a bus error for addresses outside the SRAM window without touching the SRAM. Sits between the prefetch buffer and the instruction memory in the small-core / simulation top.

Parameters:
MemBase, 32'h0000_0000, byte base address of the SRAM window; word aligned.
MemSizeWords, 4096, SRAM depth in 32-bit words; power of two, at least 2.
ReadLatency, 1, cycles from gnt to rvalid; legal range 1..4.
MaxOutstanding, 2, maximum granted-but-unreturned requests; legal range 1..4.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
instr_req_i  in  1  request from prefetch buffer
instr_addr_i  in  32  request byte address; bits [1:0] ignored
instr_gnt_o  out  1  request accepted this cycle
instr_rvalid_o  out  1  response valid
instr_rdata_o  out  32  response data
instr_err_o  out  1  response is an address error; qualified by rvalid
sram_req_o  out  1  SRAM read strobe
sram_addr_o  out  $clog2(MemSizeWords)  SRAM word address
sram_rdata_i  in  32  SRAM data, valid the cycle after sram_req_o
busy_o  out  1  any request outstanding

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, sram_req_o=0, sram_addr_o=0, busy_o=0. Outstanding count=0.
- Reset mid-operation: all in-flight responses are dropped. No rvalid is produced for any request granted before reset.
- Grant rule: combinational; instr_gnt_o = instr_req_i & (cnt_q < MaxOutstanding | retire).
  - retire = instr_rvalid_o this cycle.
  - A slot freed this cycle can be granted in the same cycle, giving full throughput when MaxOutstanding >= ReadLatency.
- No address dependency on gnt: an ungranted request may change address; the adapter keeps no state for ungranted requests.
- Range check on a granted request: in_range = (addr >= MemBase) & (addr < MemBase + 4*MemSizeWords).
  - Compute in 33 bits so MemBase near 2^32 does not wrap.
  - in_range granted request: sram_req_o=1 and sram_addr_o=(addr-MemBase)[2+:AW], both in the gnt cycle.
  - out-of-range granted request: sram_req_o=0; the request is tagged err.
- Response pipe: a delay line of depth ReadLatency carrying {valid, err}. Entry is pushed on gnt and emerges exactly ReadLatency cycles later as instr_rvalid_o.
  - Data path:
    - ReadLatency=1: SRAM data is presented directly.
    - ReadLatency>1: SRAM data is captured the cycle after sram_req_o and shifted alongside the tag for the remaining ReadLatency-1 stages.
  - Responses are strictly in order; there is no backpressure on rvalid.
  - With err=1: instr_rdata_o = 32'h0. With rvalid=0: instr_rdata_o = 32'h0.
  - instr_err_o is 0 whenever rvalid=0.
- Outstanding counter: cnt_d = cnt_q + gnt - retire. Width $clog2(MaxOutstanding+1).
  - Simultaneous gnt and retire: count unchanged.
  - Full (cnt_q=MaxOutstanding) with no retire: gnt=0.
  - Underflow is illegal; assert retire -> cnt_q>0.
- busy_o = (cnt_q != 0) | instr_req_i.
- Assertions:
  - gnt -> req.
  - rvalid count equals gnt count delayed by ReadLatency.
  - cnt_q <= MaxOutstanding.
  - Parameter legality at elaboration.

Decomposition:
- Package ibex_instr_mem_pkg:
  - rsp_tag_t struct {logic valid; logic err;}
  - constants MaxReadLatency=4 and MaxOutstandingLimit=4.
  - function addr_in_range(addr, base, size_words).
- Sub-module ibex_instr_rsp_pipe:
  - parameterised depth-N delay line of rsp_tag_t plus 32-bit data.
  - data is loaded at stage 1 from sram_rdata_i.
  - synchronous active-high clear.
- The top holds the grant logic, range check, counter and outputs.

Test Plan:
- Single fetch, ReadLatency=1, mem[3]=32'hDEAD_BEEF: req addr 32'hC held one cycle -> gnt same cycle, sram_addr_o=3; rvalid next cycle with rdata=32'hDEAD_BEEF, err=0.
- Back-to-back, ReadLatency=2, MaxOutstanding=2: req held high with addrs 0,4,8,12 -> gnt every cycle; rvalid on cycles 2..5 with mem[0..3] in order; cnt_q never exceeds 2.
- Throttle, ReadLatency=3, MaxOutstanding=1: continuous req -> gnt at cycles 0, 3, 6; each rvalid coincides with the next gnt.
- Out-of-range, MemBase=32'h8000_0000, MemSizeWords=16: req addr 32'h8000_0040 -> gnt=1, sram_req_o=0, rvalid after ReadLatency with err=1, rdata=0. Req addr 32'h8000_003C -> err=0.
- Wrap check, MemBase=32'hFFFF_FFC0, MemSizeWords=16: addr 32'h0000_0000 -> err=1. Addr 32'hFFFF_FFFC -> err=0, sram_addr_o=15.
- Reset mid-flight, ReadLatency=3: two grants, then rst_i=1 for one cycle -> no rvalid for either request, busy_o=0 after reset, next req granted immediately.
